// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 multi-cycle sequencer and its datapath.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } seq_state_t;

    localparam logic [6:0]  ALU_WITH_TWO_REGISTERS = 7'b0110011;
    localparam logic [6:0]  ALU_WITH_IMMEDIATE     = 7'b0010011;
    localparam logic [31:0] NOP_INSN               = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        return (opc == ALU_WITH_TWO_REGISTERS) || (opc == ALU_WITH_IMMEDIATE);
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts FETCH cycles without an ack; flags expiry and keeps a sticky timeout bit.
module fetch_watchdog #(
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetching,
    input  logic ack,
    output logic expire,
    output logic timed_out
);
    localparam int CW = ($clog2(FETCH_TIMEOUT + 1) > 4) ? $clog2(FETCH_TIMEOUT + 1) : 4;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timed_out_q, timed_out_d;

    // Counter holds zero outside FETCH, so it is already clear on FETCH entry.
    always_comb begin
        cnt_d       = '0;
        expire      = fetching && !ack && (cnt_q == CW'(FETCH_TIMEOUT - 1));
        timed_out_d = timed_out_q | expire;
        if (fetching && !ack)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning PC, IR and retire count.
// Optional fetch watchdog enabled by defining CPU_SEQ_FETCH_TIMEOUT_EN.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS    = 32,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        reg_write_en,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic        fetch_timeout,
    output logic [31:0] retired
);
    localparam logic [31:0] PC_MASK = 32'(4 * IMEM_WORDS - 1);

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;
    logic        single_q, single_d;
    logic        illegal_q, illegal_d;
    logic        fetch_expire;

`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_fetch_watchdog (
        .clk      (clk),
        .rst_n    (reset),
        .fetching (state_q == S_FETCH),
        .ack      (imem_ack),
        .expire   (fetch_expire),
        .timed_out(fetch_timeout)
    );
`else
    assign fetch_expire  = 1'b0;
    assign fetch_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        single_d  = single_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d  = S_FETCH;
                    single_d = step && !run;
                end
            end
            S_FETCH: begin
                // An ack in the expiry cycle takes priority over the watchdog.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (fetch_expire) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_legal_opcode(ir_q[6:0])) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXECUTE: state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                pc_d      = (pc_q + 32'd4) & PC_MASK;
                retired_d = retired_q + 32'd1;
                if (run && !single_q) begin
                    state_d = S_FETCH;
                end else begin
                    state_d  = S_IDLE;
                    single_d = 1'b0;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= NOP_INSN;
            retired_q <= '0;
            single_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            single_q  <= single_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs decode only registered state, so there is no input-to-output path.
    assign imem_req     = (state_q == S_FETCH);
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign retired      = retired_q;
    assign illegal      = illegal_q;
    assign reg_write_en = (state_q == S_WRITEBACK) && (ir_q[11:7] != 5'd0);
    assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted       = (state_q == S_HALT);

endmodule
